// File: rtl/cpu_pkg.sv
// Shared CPU types: next-PC op encodings and the PC value type.
package cpu_pkg;

    localparam int PC_W = 32;

    typedef logic [PC_W-1:0] pc_t;
    typedef logic [2:0]      op_t;

    localparam op_t OP_SEQ    = 3'd0;
    localparam op_t OP_BRANCH = 3'd1;
    localparam op_t OP_JUMP   = 3'd2;
    localparam op_t OP_CALL   = 3'd3;
    localparam op_t OP_RET    = 3'd4;

endpackage

// File: rtl/pc_seq_if.sv
// Control/status bundle between the fetch controller and pc_seq.
interface pc_seq_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic [2:0]       op;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] offset;
    logic             err_clr;
    logic [WIDTH-1:0] pc_out;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_ovf;
    logic             ras_unf;

    modport master (
        output en, op, target, offset, err_clr,
        input  pc_out, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  en, op, target, offset, err_clr,
        output pc_out, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full,
    output logic             ovf_evt,
    output logic             unf_evt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign ovf_evt  = push && full;
    assign unf_evt  = pop && empty;
    assign wr_ptr   = ptr + 1'b1;
    assign top_data = mem[ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= wr_ptr;
            if (!full) cnt <= cnt + 1'b1;
        end else if (pop && !empty) begin
            ptr <= ptr - 1'b1;
            cnt <= cnt - 1'b1;
        end
    end

    // Entry contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_seq.sv
// Fetch-stage program-counter sequencer with call/return stack.
module pc_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RESET_PC  = 0,
    parameter int STEP      = 1,
    parameter int RAS_DEPTH = 4
) (
    input logic   clk,
    input logic   clr_n,
    pc_seq_if.slave bus
);
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] top;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic             ovf_evt;
    logic             unf_evt;
    logic             ovf_q;
    logic             unf_q;

    assign seq_pc = pc_q + WIDTH'(STEP);
    assign push   = bus.en && (bus.op == OP_CALL);
    assign pop    = bus.en && (bus.op == OP_RET);

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (clr_n),
        .push      (push),
        .pop       (pop),
        .push_data (seq_pc),
        .top_data  (top),
        .empty     (empty),
        .full      (full),
        .ovf_evt   (ovf_evt),
        .unf_evt   (unf_evt)
    );

    // RET on an empty stack falls through as a sequential step.
    always_comb begin
        pc_d = seq_pc;
        case (bus.op)
            OP_BRANCH: pc_d = pc_q + bus.offset;
            OP_JUMP:   pc_d = bus.target;
            OP_CALL:   pc_d = bus.target;
            OP_RET:    if (!empty) pc_d = top;
            default:   pc_d = seq_pc;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) pc_q <= WIDTH'(RESET_PC);
        else if (bus.en) pc_q <= pc_d;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_evt) ovf_q <= 1'b1;
            else if (bus.err_clr) ovf_q <= 1'b0;
            if (unf_evt) unf_q <= 1'b1;
            else if (bus.err_clr) unf_q <= 1'b0;
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.ras_empty = empty;
    assign bus.ras_full  = full;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;

endmodule
